// File: rtl/nn_pkg.sv
// Shared types and default sizes for the fully-connected layer datapath.
package nn_pkg;

    localparam int unsigned Q15_W           = 16;
    localparam int unsigned DEF_NUM_INPUTS  = 784;
    localparam int unsigned DEF_NUM_NEURONS = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        DRAIN    = 2'd2,
        WAIT_RES = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/feeder_rd_pipe.sv
// Aligns memory read data with its issue strobe and presents registered
// beat and bias words to the neuron.
module feeder_rd_pipe
    import nn_pkg::*;
#(
    parameter int unsigned W = Q15_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_i,
    input  logic         bias_ld_i,
    input  logic [W-1:0] pix_rdata_i,
    input  logic [W-1:0] w_rdata_i,
    input  logic [W-1:0] b_rdata_i,
    output logic [W-1:0] nd_data_o,
    output logic [W-1:0] nd_weight_o,
    output logic [W-1:0] nd_bias_o,
    output logic         nd_valid_o
);

    logic         rd_vld_q;
    logic         bias_ld_q;
    logic         nd_valid_q;
    logic [W-1:0] nd_data_q;
    logic [W-1:0] nd_weight_q;
    logic [W-1:0] nd_bias_q;

    // Stage 1 marks the cycle rdata is valid; stage 2 captures it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_q    <= 1'b0;
            bias_ld_q   <= 1'b0;
            nd_valid_q  <= 1'b0;
            nd_data_q   <= '0;
            nd_weight_q <= '0;
            nd_bias_q   <= '0;
        end else begin
            rd_vld_q   <= issue_i;
            bias_ld_q  <= bias_ld_i;
            nd_valid_q <= rd_vld_q;
            if (rd_vld_q) begin
                nd_data_q   <= pix_rdata_i;
                nd_weight_q <= w_rdata_i;
            end
            if (bias_ld_q) begin
                nd_bias_q <= b_rdata_i;
            end
        end
    end

    assign nd_data_o   = nd_data_q;
    assign nd_weight_o = nd_weight_q;
    assign nd_bias_o   = nd_bias_q;
    assign nd_valid_o  = nd_valid_q;

endmodule

// File: rtl/neuron_feeder.sv
// Sequences pixel/weight/bias reads into one shared MAC neuron, once per
// output neuron, and forwards each result tagged with its neuron index.
module neuron_feeder
    import nn_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = Q15_W,
    parameter int unsigned NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int unsigned PA_W        = $clog2(NUM_INPUTS),
    parameter int unsigned WA_W        = $clog2(NUM_INPUTS * NUM_NEURONS),
    parameter int unsigned NI_W        = $clog2(NUM_NEURONS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [PA_W-1:0]     pix_addr,
    input  logic [IN_WIDTH-1:0] pix_rdata,
    output logic [WA_W-1:0]     w_addr,
    input  logic [IN_WIDTH-1:0] w_rdata,
    output logic [NI_W-1:0]     b_addr,
    input  logic [IN_WIDTH-1:0] b_rdata,
    output logic [IN_WIDTH-1:0] nd_data,
    output logic [IN_WIDTH-1:0] nd_weight,
    output logic [IN_WIDTH-1:0] nd_bias,
    output logic                nd_valid,
    input  logic [IN_WIDTH-1:0] nr_data,
    input  logic                nr_valid,
    output logic [IN_WIDTH-1:0] res_data,
    output logic [NI_W-1:0]     res_idx,
    output logic                res_valid
);

    localparam logic [PA_W-1:0] LAST_I = PA_W'(NUM_INPUTS - 1);
    localparam logic [NI_W-1:0] LAST_N = NI_W'(NUM_NEURONS - 1);

    feeder_state_e       state_q,     state_d;
    logic [PA_W-1:0]     i_q,         i_d;
    logic [NI_W-1:0]     n_q,         n_d;
    logic [WA_W-1:0]     w_addr_q,    w_addr_d;
    logic [NI_W-1:0]     b_addr_q,    b_addr_d;
    logic                drain_q,     drain_d;
    logic                issue_q,     issue_d;
    logic                bias_ld_q,   bias_ld_d;
    logic [IN_WIDTH-1:0] res_data_q,  res_data_d;
    logic [NI_W-1:0]     res_idx_q,   res_idx_d;
    logic                res_valid_q, res_valid_d;
    logic                last_q,      last_d;
    logic                done_q,      done_d;
    logic                busy_q,      busy_d;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        n_d         = n_q;
        w_addr_d    = w_addr_q;
        b_addr_d    = b_addr_q;
        drain_d     = drain_q;
        issue_d     = 1'b0;
        bias_ld_d   = 1'b0;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_valid_d = 1'b0;
        last_d      = 1'b0;
        done_d      = last_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = STREAM;
                    i_d       = '0;
                    n_d       = '0;
                    w_addr_d  = '0;
                    b_addr_d  = '0;
                    issue_d   = 1'b1;
                    bias_ld_d = 1'b1;
                end
            end
            STREAM: begin
                if (i_q == LAST_I) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    i_d      = i_q + PA_W'(1);
                    w_addr_d = w_addr_q + WA_W'(1);
                    issue_d  = 1'b1;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = WAIT_RES;
                    drain_d = 1'b0;
                end
            end
            WAIT_RES: begin
                if (nr_valid) begin
                    res_data_d  = nr_data;
                    res_idx_d   = n_q;
                    res_valid_d = 1'b1;
                    if (n_q == LAST_N) begin
                        state_d = IDLE;
                        last_d  = 1'b1;
                    end else begin
                        // Weight address keeps running across neurons.
                        state_d   = STREAM;
                        n_d       = n_q + NI_W'(1);
                        b_addr_d  = n_q + NI_W'(1);
                        i_d       = '0;
                        w_addr_d  = w_addr_q + WA_W'(1);
                        issue_d   = 1'b1;
                        bias_ld_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            n_q         <= '0;
            w_addr_q    <= '0;
            b_addr_q    <= '0;
            drain_q     <= 1'b0;
            issue_q     <= 1'b0;
            bias_ld_q   <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            n_q         <= n_d;
            w_addr_q    <= w_addr_d;
            b_addr_q    <= b_addr_d;
            drain_q     <= drain_d;
            issue_q     <= issue_d;
            bias_ld_q   <= bias_ld_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_valid_q <= res_valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    feeder_rd_pipe #(
        .W(IN_WIDTH)
    ) u_rd_pipe (
        .clk        (clk),
        .rst        (rst),
        .issue_i    (issue_q),
        .bias_ld_i  (bias_ld_q),
        .pix_rdata_i(pix_rdata),
        .w_rdata_i  (w_rdata),
        .b_rdata_i  (b_rdata),
        .nd_data_o  (nd_data),
        .nd_weight_o(nd_weight),
        .nd_bias_o  (nd_bias),
        .nd_valid_o (nd_valid)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_addr  = i_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = b_addr_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder with 4 inputs x 3 neurons, 1-cycle memories and a
// behavioural MAC neuron; results are scoreboarded against a reference sum.
module tb_neuron_feeder;

    localparam int unsigned NI = 4;
    localparam int unsigned NN = 3;
    localparam int unsigned NEURON_LAT = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  pix_addr;
    logic [15:0] pix_rdata;
    logic [3:0]  w_addr;
    logic [15:0] w_rdata;
    logic [1:0]  b_addr;
    logic [15:0] b_rdata;
    logic [15:0] nd_data;
    logic [15:0] nd_weight;
    logic [15:0] nd_bias;
    logic        nd_valid;
    logic [15:0] nr_data;
    logic        nr_valid;
    logic [15:0] res_data;
    logic [1:0]  res_idx;
    logic        res_valid;

    logic [15:0] pix_mem [4];
    logic [15:0] w_mem   [16];
    logic [15:0] b_mem   [4];

    logic        inj;
    logic        nm_valid;
    logic [15:0] nm_data;
    logic [15:0] nm_res;
    logic signed [39:0] nm_acc;
    logic signed [31:0] prod;
    int          nm_cnt;
    int          nm_dly;

    int total;
    int bad;

    neuron_feeder #(
        .IN_WIDTH   (16),
        .NUM_INPUTS (NI),
        .NUM_NEURONS(NN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pix_addr (pix_addr),
        .pix_rdata(pix_rdata),
        .w_addr   (w_addr),
        .w_rdata  (w_rdata),
        .b_addr   (b_addr),
        .b_rdata  (b_rdata),
        .nd_data  (nd_data),
        .nd_weight(nd_weight),
        .nd_bias  (nd_bias),
        .nd_valid (nd_valid),
        .nr_data  (nr_data),
        .nr_valid (nr_valid),
        .res_data (res_data),
        .res_idx  (res_idx),
        .res_valid(res_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memories.
    always @(posedge clk) begin
        pix_rdata <= pix_mem[pix_addr];
        w_rdata   <= w_mem[w_addr];
        b_rdata   <= b_mem[b_addr];
    end

    // MAC neuron: accumulate NI products, add bias on the last beat, answer after NEURON_LAT.
    assign prod = $signed(nd_data) * $signed(nd_weight);
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            nm_acc   <= '0;
            nm_cnt   <= 0;
            nm_dly   <= 0;
            nm_valid <= 1'b0;
            nm_data  <= '0;
            nm_res   <= '0;
        end else begin
            nm_valid <= 1'b0;
            if (nm_dly == 1) begin
                nm_valid <= 1'b1;
                nm_data  <= nm_res;
            end
            if (nm_dly != 0) nm_dly <= nm_dly - 1;
            if (nd_valid) begin
                if (nm_cnt == NI - 1) begin
                    nm_res <= 16'((nm_acc + prod) >>> 15) + nd_bias;
                    nm_acc <= '0;
                    nm_cnt <= 0;
                    nm_dly <= NEURON_LAT;
                end else begin
                    nm_acc <= nm_acc + prod;
                    nm_cnt <= nm_cnt + 1;
                end
            end
        end
    end

    assign nr_valid = nm_valid | inj;
    assign nr_data  = nm_valid ? nm_data : 16'h7ABC;

    function automatic logic [15:0] model_res(input int n);
        longint acc;
        acc = 0;
        for (int i = 0; i < NI; i++) begin
            acc += longint'($signed(pix_mem[i])) * longint'($signed(w_mem[n*NI + i]));
        end
        return 16'(acc >>> 15) + b_mem[n];
    endfunction

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 4; i++) pix_mem[i] = (mode == 0) ? 16'(i + 1) : 16'($urandom_range(0, 65535));
        for (int i = 0; i < 16; i++) w_mem[i] = (mode == 0) ? 16'h4000 : 16'($urandom_range(0, 65535));
        for (int i = 0; i < 4; i++) b_mem[i] = 16'h0000;
    endtask

    // One layer pass: drives start, scoreboards beats/results/done until done or budget.
    task automatic run_pass(input bit spam, input bit inject, input int abort_at,
                            output int beats, output int nres, output int ndone,
                            output int first_nd, output int last_nd0, output bit aborted);
        logic [15:0] exp_d[$];
        logic [1:0]  exp_i[$];
        logic [15:0] ed;
        logic [1:0]  ei;
        int cyc, bi, last_res;
        bit prev_v;
        beats = 0; nres = 0; ndone = 0; first_nd = -1; last_nd0 = -1; aborted = 1'b0;
        bi = 0; last_res = -10; prev_v = 1'b0;
        for (int n = 0; n < NN; n++) begin
            exp_d.push_back(model_res(n));
            exp_i.push_back(2'(n));
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!spam) start = 1'b0;
        cyc = 0;
        total++;
        if (w_addr !== 4'd0 || pix_addr !== 2'd0 || b_addr !== 2'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pass_entry: w_addr=%0d pix_addr=%0d b_addr=%0d busy=%b want 0 0 0 1",
                     w_addr, pix_addr, b_addr, busy);
        end
        while (ndone == 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            inj = (inject && cyc == 2);
            if (spam && nres >= 2) start = 1'b0;
            if (!res_valid && nres < NN) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_in_pass: cyc=%0d busy=%b want 1", cyc, busy);
                end
            end
            if (nd_valid) begin
                total++;
                if (bi >= NI * NN) begin
                    bad++;
                    $display("FAIL extra_beat: beat=%0d beyond %0d", bi, NI * NN);
                end else if (nd_data !== pix_mem[bi % NI] || nd_weight !== w_mem[bi] ||
                             nd_bias !== b_mem[bi / NI]) begin
                    bad++;
                    $display("FAIL beat%0d: data=%h wt=%h bias=%h want %h %h %h", bi, nd_data,
                             nd_weight, nd_bias, pix_mem[bi % NI], w_mem[bi], b_mem[bi / NI]);
                end
                if (bi % NI != 0) begin
                    total++;
                    if (!prev_v) begin
                        bad++;
                        $display("FAIL beat_gap: beat=%0d prev_valid=%b want 1", bi, prev_v);
                    end
                end
                if (bi == 0) first_nd = cyc;
                if (bi == NI - 1) last_nd0 = cyc;
                bi++;
                beats++;
            end
            prev_v = nd_valid;
            if (res_valid) begin
                total++;
                if (exp_d.size() == 0) begin
                    bad++;
                    $display("FAIL res_extra: data=%h idx=%0d want none", res_data, res_idx);
                end else begin
                    ed = exp_d.pop_front();
                    ei = exp_i.pop_front();
                    if (res_data !== ed || res_idx !== ei) begin
                        bad++;
                        $display("FAIL res: data=%h idx=%0d want %h %0d", res_data, res_idx, ed, ei);
                    end
                end
                nres++;
                last_res = cyc;
            end
            if (done) begin
                total++;
                if (cyc != last_res + 1 || nres != NN) begin
                    bad++;
                    $display("FAIL done_timing: cyc=%0d last_res=%0d nres=%0d want cyc=last_res+1 nres=%0d",
                             cyc, last_res, nres, NN);
                end
                ndone++;
            end
            if (abort_at >= 0 && bi == abort_at) begin
                aborted = 1'b1;
                start = 1'b0;
                inj = 1'b0;
                return;
            end
        end
        start = 1'b0;
        inj = 1'b0;
        if (ndone == 0) begin
            total++;
            bad++;
            $display("FAIL pass_timeout: no done within %0d cycles", cyc);
        end
        repeat (8) begin
            @(negedge clk);
            if (res_valid) nres++;
            if (done) ndone++;
            if (nd_valid) beats++;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_after_done: busy=%b want 0", busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, pix_addr, w_addr, b_addr, nd_valid, res_valid, res_idx} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b done=%b pa=%0d wa=%0d ba=%0d ndv=%b rv=%b ri=%0d want all 0",
                     busy, done, pix_addr, w_addr, b_addr, nd_valid, res_valid, res_idx);
        end
        total++;
        if ({nd_data, nd_weight, nd_bias, res_data} !== '0) begin
            bad++;
            $display("FAIL reset_data: nd=%h nw=%h nb=%h rd=%h want 0", nd_data, nd_weight, nd_bias, res_data);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int beats, nres, ndone, f, l;
        bit ab;
        fill_mem(0);
        run_pass(1'b0, 1'b0, -1, beats, nres, ndone, f, l, ab);
        total++;
        if (beats != NI * NN || nres != NN || ndone != 1) begin
            bad++;
            $display("FAIL basic_counts: beats=%0d res=%0d done=%0d want %0d %0d 1", beats, nres, ndone, NI * NN, NN);
        end
    endtask

    task automatic test_latency();
        int beats, nres, ndone, f, l;
        bit ab;
        fill_mem(1);
        run_pass(1'b0, 1'b0, -1, beats, nres, ndone, f, l, ab);
        total++;
        if (f != 2 || l != 5) begin
            bad++;
            $display("FAIL latency: first_nd=%0d last_nd0=%0d want 2 5", f, l);
        end
        total++;
        if (beats != NI * NN || nres != NN || ndone != 1) begin
            bad++;
            $display("FAIL latency_counts: beats=%0d res=%0d done=%0d want %0d %0d 1", beats, nres, ndone, NI * NN, NN);
        end
    endtask

    task automatic test_bias();
        int beats, nres, ndone, f, l;
        bit ab;
        fill_mem(1);
        b_mem[0] = 16'h1111;
        b_mem[1] = 16'h2222;
        b_mem[2] = 16'h3333;
        run_pass(1'b0, 1'b0, -1, beats, nres, ndone, f, l, ab);
        total++;
        if (beats != NI * NN || nres != NN || ndone != 1) begin
            bad++;
            $display("FAIL bias_counts: beats=%0d res=%0d done=%0d want %0d %0d 1", beats, nres, ndone, NI * NN, NN);
        end
        total++;
        if (nd_bias !== 16'h3333) begin
            bad++;
            $display("FAIL bias_hold: nd_bias=%h want 3333", nd_bias);
        end
    endtask

    task automatic test_spurious();
        int beats, nres, ndone, f, l;
        bit ab;
        fill_mem(1);
        b_mem[1] = 16'h0101;
        run_pass(1'b0, 1'b1, -1, beats, nres, ndone, f, l, ab);
        total++;
        if (nres != NN || ndone != 1) begin
            bad++;
            $display("FAIL spurious_counts: res=%0d done=%0d want %0d 1", nres, ndone, NN);
        end
    endtask

    task automatic test_start_spam();
        int beats, nres, ndone, f, l;
        bit ab;
        fill_mem(1);
        run_pass(1'b1, 1'b0, -1, beats, nres, ndone, f, l, ab);
        total++;
        if (beats != NI * NN || nres != NN || ndone != 1) begin
            bad++;
            $display("FAIL spam_counts: beats=%0d res=%0d done=%0d want %0d %0d 1", beats, nres, ndone, NI * NN, NN);
        end
    endtask

    task automatic test_abort_reset();
        int beats, nres, ndone, f, l;
        bit ab;
        fill_mem(1);
        run_pass(1'b0, 1'b0, NI + 2, beats, nres, ndone, f, l, ab);
        total++;
        if (!ab || nres != 1) begin
            bad++;
            $display("FAIL abort_reach: aborted=%b res=%0d want 1 1", ab, nres);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({busy, done, pix_addr, w_addr, b_addr, nd_valid, res_valid, res_idx} !== '0 ||
            {nd_data, nd_weight, nd_bias, res_data} !== '0) begin
            bad++;
            $display("FAIL abort_async: busy=%b done=%b pa=%0d wa=%0d ba=%0d ndv=%b nd=%h rd=%h want all 0",
                     busy, done, pix_addr, w_addr, b_addr, nd_valid, nd_data, res_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy || res_valid) ndone++;
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL abort_quiet: active_cycles=%0d want 0", ndone);
        end
        run_pass(1'b0, 1'b0, -1, beats, nres, ndone, f, l, ab);
        total++;
        if (beats != NI * NN || nres != NN || ndone != 1 || f != 2) begin
            bad++;
            $display("FAIL restart_counts: beats=%0d res=%0d done=%0d first=%0d want %0d %0d 1 2",
                     beats, nres, ndone, f, NI * NN, NN);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        start = 1'b0;
        inj   = 1'b0;
        fill_mem(0);
        test_reset();
        test_basic();
        test_latency();
        test_bias();
        test_spurious();
        test_start_spam();
        test_abort_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
